// File: rtl/data_ram_mmio_if.sv
// Load/store request bus between the MEM stage (master) and the data-side responder (slave).
interface data_ram_mmio_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (
      output ce_i,
      output we_i,
      output addr_i,
      output sel_i,
      output data_i,
      input  data_o
   );

   modport slave (
      input  ce_i,
      input  we_i,
      input  addr_i,
      input  sel_i,
      input  data_i,
      output data_o
   );
endinterface

// File: rtl/data_ram_mmio.sv
// Data-side responder: byte-lane data RAM at 0x0xxx_xxxx, LED/timer/cycle MMIO at 0x1xxx_xxxx.
// Loads are combinational; stores commit on the rising clock edge.
module data_ram_mmio #(
   parameter int unsigned RAM_AW = 17,
   parameter int unsigned LED_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   data_ram_mmio_if.slave   bus,
   output logic [LED_W-1:0] led_o,
   output logic             irq_o
);

   typedef enum logic [2:0] {
      REG_LED    = 3'd0,
      REG_TCOUNT = 3'd1,
      REG_TCMP   = 3'd2,
      REG_CTRL   = 3'd3,
      REG_STATUS = 3'd4,
      REG_CYCLE  = 3'd5,
      REG_RSVD6  = 3'd6,
      REG_RSVD7  = 3'd7
   } reg_e;

   logic [31:0]       mem [0:(1 << RAM_AW) - 1];

   logic              ram_hit;
   logic              mmio_hit;
   logic              rd_en;
   logic              ram_wr;
   logic              mmio_wr;
   logic [RAM_AW-1:0] ram_idx;
   reg_e              reg_sel;
   logic [31:0]       lane_mask;
   logic [31:0]       reg_cur;
   logic [31:0]       wr_word;
   logic [31:0]       rd_data;
   logic              timer_hit;
   logic              unused_addr_bits;

   logic [LED_W-1:0]  led_q, led_d;
   logic [31:0]       tcount_q, tcount_d;
   logic [31:0]       tcmp_q, tcmp_d;
   logic              ctrl_en_q, ctrl_en_d;
   logic              match_q, match_d;
   logic [31:0]       cycle_q, cycle_d;

   // Decode.
   always_comb begin
      ram_hit   = (bus.addr_i[31:28] == 4'h0);
      mmio_hit  = (bus.addr_i[31:28] == 4'h1);
      rd_en     = bus.ce_i & ~bus.we_i;
      ram_wr    = bus.ce_i & bus.we_i & ram_hit & ~rst;
      mmio_wr   = bus.ce_i & bus.we_i & mmio_hit;
      ram_idx   = bus.addr_i[RAM_AW+1:2];
      reg_sel   = reg_e'(bus.addr_i[4:2]);
      lane_mask = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}},
                   {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};
   end

   assign unused_addr_bits = ^{bus.addr_i[27:RAM_AW+2], bus.addr_i[1:0]};

   // Current value of the addressed register; serves both the load path and
   // the base word for partial-lane stores.
   always_comb begin
      reg_cur = '0;
      case (reg_sel)
         REG_LED:    reg_cur = 32'(led_q);
         REG_TCOUNT: reg_cur = tcount_q;
         REG_TCMP:   reg_cur = tcmp_q;
         REG_CTRL:   reg_cur = {31'd0, ctrl_en_q};
         REG_STATUS: reg_cur = {31'd0, match_q};
         REG_CYCLE:  reg_cur = cycle_q;
         default:    reg_cur = '0;
      endcase
   end

   assign wr_word = (reg_cur & ~lane_mask) | (bus.data_i & lane_mask);

   always_comb begin
      rd_data = '0;
      if (rd_en) begin
         if (ram_hit) begin
            rd_data = mem[ram_idx];
         end else if (mmio_hit) begin
            rd_data = reg_cur;
         end
      end
   end

   assign bus.data_o = rd_data;

   // Register next-state; CPU writes override the timer's own update.
   always_comb begin
      timer_hit = ctrl_en_q && (tcount_q == tcmp_q);
      led_d     = led_q;
      tcmp_d    = tcmp_q;
      ctrl_en_d = ctrl_en_q;
      match_d   = match_q;
      cycle_d   = cycle_q + 32'd1;

      if (timer_hit) begin
         tcount_d = '0;
      end else if (ctrl_en_q) begin
         tcount_d = tcount_q + 32'd1;
      end else begin
         tcount_d = tcount_q;
      end

      if (mmio_wr) begin
         case (reg_sel)
            REG_LED:    led_d     = wr_word[LED_W-1:0];
            REG_TCOUNT: tcount_d  = wr_word;
            REG_TCMP:   tcmp_d    = wr_word;
            REG_CTRL:   ctrl_en_d = wr_word[0];
            REG_STATUS: begin
               if (bus.sel_i[0] && bus.data_i[0]) begin
                  match_d = 1'b0;
               end
            end
            default: ;
         endcase
      end

      // A match event outranks a same-cycle W1C clear.
      if (timer_hit) begin
         match_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q     <= '0;
         tcount_q  <= '0;
         tcmp_q    <= '1;
         ctrl_en_q <= 1'b0;
         match_q   <= 1'b0;
         cycle_q   <= '0;
      end else begin
         led_q     <= led_d;
         tcount_q  <= tcount_d;
         tcmp_q    <= tcmp_d;
         ctrl_en_q <= ctrl_en_d;
         match_q   <= match_d;
         cycle_q   <= cycle_d;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (bus.sel_i[b]) begin
               mem[ram_idx][8*b +: 8] <= bus.data_i[8*b +: 8];
            end
         end
      end
   end

   assign led_o = led_q;
   assign irq_o = match_q;

endmodule
